// File: rtl/ebi_decoder.sv
// ebi_decoder
//   Front end between the AT91 external bus interface and the peripheral
//   data-bus mux. The asynchronous EBI strobes are double-flopped, and the
//   address is decoded into one-hot peripheral chip selects. The register
//   offset and write data are latched, single-cycle read/write strobes are
//   generated, and nWAIT is held low so that every access is stretched by
//   WAIT_CYCLES wait states.
//
// Ports
//   CLK, nRESET      clock (rising edge), asynchronous active-low reset
//   nCS, nRD, nWE    EBI chip select / read / write strobes (async, active low)
//   A                EBI address: [AW-1:AW-3] device field, [AW-4:0] offset
//   DIN              EBI write data
//   CSUART0..3,
//   CSPIC, CSCONS    one-hot peripheral selects
//   nRW              0 = read cycle (mux drives the bus), 1 = write or idle
//   REG              latched register offset
//   WDATA            latched write data
//   RD_STB, WR_STB   single-cycle read side-effect / write pulses
//   nWAIT            EBI wait request, active low
module ebi_decoder #(
  parameter int BW          = 7,
  parameter int AW          = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          nCS,
  input  logic          nRD,
  input  logic          nWE,
  input  logic [AW-1:0] A,
  input  logic [BW:0]   DIN,
  output logic          CSUART0,
  output logic          CSUART1,
  output logic          CSUART2,
  output logic          CSUART3,
  output logic          CSPIC,
  output logic          CSCONS,
  output logic          nRW,
  output logic [AW-4:0] REG,
  output logic [BW:0]   WDATA,
  output logic          RD_STB,
  output logic          WR_STB,
  output logic          nWAIT
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Two-flop synchronizers; bit 1 is the synchronized copy.
  logic [1:0] ncs_sync_q, nrd_sync_q, nwe_sync_q;
  logic       s_ncs, s_nrd, s_nwe;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [5:0]    cs_q, cs_d, cs_dec;
  logic          nrw_q, nrw_d;
  logic [AW-4:0] reg_q, reg_d;
  logic [BW:0]   wdata_q, wdata_d;
  logic          rd_stb_q, rd_stb_d;
  logic          wr_stb_q, wr_stb_d;
  logic          nwait_q, nwait_d;
  logic          rd_q, rd_d;     // current access is a read
  logic          map_q, map_d;   // current access hits a mapped device
  logic          abort;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ncs_sync_q <= 2'b11;
      nrd_sync_q <= 2'b11;
      nwe_sync_q <= 2'b11;
    end else begin
      ncs_sync_q <= {ncs_sync_q[0], nCS};
      nrd_sync_q <= {nrd_sync_q[0], nRD};
      nwe_sync_q <= {nwe_sync_q[0], nWE};
    end
  end

  assign s_ncs = ncs_sync_q[1];
  assign s_nrd = nrd_sync_q[1];
  assign s_nwe = nwe_sync_q[1];

  // Bit order of cs: {CONS, PIC, UART3, UART2, UART1, UART0}.
  always_comb begin
    cs_dec = 6'b000000;
    case (A[AW-1:AW-3])
      3'b000:  cs_dec = 6'b000001;
      3'b001:  cs_dec = 6'b000010;
      3'b010:  cs_dec = 6'b000100;
      3'b011:  cs_dec = 6'b001000;
      3'b100:  cs_dec = 6'b010000;
      3'b101:  cs_dec = 6'b100000;
      default: cs_dec = 6'b000000;
    endcase
  end

  // The access ends when chip select or the strobe that started it goes away.
  assign abort   = s_ncs | (rd_q ? s_nrd : s_nwe);
  assign cnt_nxt = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cs_d     = cs_q;
    nrw_d    = nrw_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    nwait_d  = nwait_q;
    rd_d     = rd_q;
    map_d    = map_q;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Exactly one strobe must be active; both low is a protocol error.
        if (!s_ncs && (s_nrd != s_nwe)) begin
          state_d = DECODE;
          nwait_d = 1'b0;
          rd_d    = ~s_nrd;
        end
      end
      DECODE: begin
        if (abort) begin
          state_d = IDLE;
          cs_d    = 6'b000000;
          nrw_d   = 1'b1;
          nwait_d = 1'b1;
        end else begin
          state_d  = ACCESS;
          cnt_d    = '0;
          reg_d    = A[AW-4:0];
          if (!rd_q) wdata_d = DIN;
          nrw_d    = ~rd_q;
          cs_d     = cs_dec;
          map_d    = |cs_dec;
          wr_stb_d = ~rd_q & (|cs_dec);
          // With a single wait state the first ACCESS cycle is also the last.
          rd_stb_d = rd_q & (|cs_dec) & (WAIT_CYCLES == 1);
        end
      end
      ACCESS: begin
        if (abort) begin
          state_d = IDLE;
          cs_d    = 6'b000000;
          nrw_d   = 1'b1;
          nwait_d = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = HOLD;
          nwait_d = 1'b1;
        end else begin
          cnt_d    = cnt_nxt;
          rd_stb_d = rd_q & map_q & (cnt_nxt == LAST);
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
          cs_d    = 6'b000000;
          nrw_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cs_q     <= 6'b000000;
      nrw_q    <= 1'b1;
      reg_q    <= '0;
      wdata_q  <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      nwait_q  <= 1'b1;
      rd_q     <= 1'b0;
      map_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      nrw_q    <= nrw_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      nwait_q  <= nwait_d;
      rd_q     <= rd_d;
      map_q    <= map_d;
    end
  end

  assign {CSCONS, CSPIC, CSUART3, CSUART2, CSUART1, CSUART0} = cs_q;
  assign nRW    = nrw_q;
  assign REG    = reg_q;
  assign WDATA  = wdata_q;
  assign RD_STB = rd_stb_q;
  assign WR_STB = wr_stb_q;
  assign nWAIT  = nwait_q;

endmodule

// File: tb/tb_ebi_decoder.sv
// Testbench for ebi_decoder: directed scenarios with literal expectations plus
// randomized EBI traffic, all checked every cycle against an edge-count
// timeline model of the access protocol.
module tb_ebi_decoder;

  localparam int BW = 7;
  localparam int AW = 6;
  localparam int W  = 2;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       nCS, nRD, nWE;
  logic [5:0] A;
  logic [7:0] DIN;
  logic       CSUART0, CSUART1, CSUART2, CSUART3, CSPIC, CSCONS;
  logic       nRW;
  logic [2:0] REG;
  logic [7:0] WDATA;
  logic       RD_STB, WR_STB, nWAIT;

  always #5 CLK = ~CLK;

  ebi_decoder #(.BW(BW), .AW(AW), .WAIT_CYCLES(W)) dut (
    .CLK(CLK), .nRESET(nRESET), .nCS(nCS), .nRD(nRD), .nWE(nWE),
    .A(A), .DIN(DIN),
    .CSUART0(CSUART0), .CSUART1(CSUART1), .CSUART2(CSUART2),
    .CSUART3(CSUART3), .CSPIC(CSPIC), .CSCONS(CSCONS),
    .nRW(nRW), .REG(REG), .WDATA(WDATA),
    .RD_STB(RD_STB), .WR_STB(WR_STB), .nWAIT(nWAIT)
  );

  // ---------------- reference model ----------------
  // Pins pass a two-stage delay; an accepted access is then tracked by the
  // number of clock edges since acceptance: edge 1 leaves DECODE, edges
  // 2..W leave non-final ACCESS cycles, edge W+1 releases nWAIT, later edges
  // are the hold phase.
  logic [2:0] s1, s2;            // {nCS, nRD, nWE}
  logic       m_busy, m_rd, m_map;
  int         m_n;
  logic [5:0] e_cs;
  logic       e_nrw, e_rd, e_wr, e_nwait;
  logic [2:0] e_reg;
  logic [7:0] e_wdata;
  wire        m_rel  = s2[2] | (m_rd ? s2[1] : s2[0]);
  wire  [5:0] dec_oh = (A[5:3] < 3'd6) ? (6'b000001 << A[5:3]) : 6'b000000;

  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      s1 <= 3'b111; s2 <= 3'b111;
      m_busy <= 1'b0; m_rd <= 1'b0; m_map <= 1'b0; m_n <= 0;
      e_cs <= 6'b0; e_nrw <= 1'b1; e_reg <= 3'b0; e_wdata <= 8'h00;
      e_rd <= 1'b0; e_wr <= 1'b0; e_nwait <= 1'b1;
    end else begin
      s1 <= {nCS, nRD, nWE};
      s2 <= s1;
      e_rd <= 1'b0;
      e_wr <= 1'b0;
      if (!m_busy) begin
        if (!s2[2] && (s2[1] != s2[0])) begin
          m_busy <= 1'b1; m_n <= 1; m_rd <= ~s2[1]; e_nwait <= 1'b0;
        end
      end else begin
        m_n <= m_n + 1;
        if (m_n <= W + 1 && m_rel) begin
          m_busy <= 1'b0; e_cs <= 6'b0; e_nrw <= 1'b1; e_nwait <= 1'b1;
        end else if (m_n == 1) begin
          e_reg <= A[2:0];
          if (!m_rd) e_wdata <= DIN;
          e_nrw <= ~m_rd;
          e_cs  <= dec_oh;
          m_map <= |dec_oh;
          e_wr  <= ~m_rd & (|dec_oh);
          e_rd  <= m_rd & (|dec_oh) & (W == 1);
        end else if (m_n <= W) begin
          if (m_n == W) e_rd <= m_rd & m_map;
        end else if (m_n == W + 1) begin
          e_nwait <= 1'b1;
        end else if (m_rel) begin
          m_busy <= 1'b0; e_cs <= 6'b0; e_nrw <= 1'b1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_wr = 0, n_rd = 0, n_wlow = 0;
  int wr0, rd0, wl0, cs_first, rd_at;
  logic [5:0] cs_seen;

  wire [5:0]  cs_v  = {CSCONS, CSPIC, CSUART3, CSUART2, CSUART1, CSUART0};
  wire [20:0] dut_v = {cs_v, nRW, REG, WDATA, RD_STB, WR_STB, nWAIT};
  wire [20:0] exp_v = {e_cs, e_nrw, e_reg, e_wdata, e_rd, e_wr, e_nwait};
  localparam logic [20:0] RST_V = {6'b0, 1'b1, 3'b0, 8'h00, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
    check("model", 32'(dut_v), 32'(exp_v));
    if (WR_STB === 1'b1) n_wr++;
    if (RD_STB === 1'b1) begin n_rd++; rd_at = cyc; end
    if (nWAIT === 1'b0) n_wlow++;
    if (cs_v != 6'b0 && cs_first < 0) cs_first = cyc;
    cs_seen |= cs_v;
  endtask

  task automatic snap();
    wr0 = n_wr; rd0 = n_rd; wl0 = n_wlow;
    cs_seen = 6'b0; cs_first = -1; rd_at = -1;
  endtask

  task automatic start(input bit rd, input logic [5:0] a, input logic [7:0] d);
    A = a; DIN = d; nCS = 1'b0;
    if (rd) nRD = 1'b0; else nWE = 1'b0;
  endtask

  task automatic release_all();
    nCS = 1'b1; nRD = 1'b1; nWE = 1'b1;
  endtask

  initial begin
    int kind, r;
    nRESET = 1'b0; nCS = 1'b1; nRD = 1'b1; nWE = 1'b1; A = 6'b0; DIN = 8'h00;
    cs_seen = 6'b0; cs_first = -1; rd_at = -1;
    repeat (3) tick();
    check("reset_state", 32'(dut_v), 32'(RST_V));
    nRESET = 1'b1;
    repeat (2) tick();

    // write to UART1
    snap(); start(1'b0, 6'b001011, 8'hA5);
    repeat (8) tick();
    check("wr_u1_cs", 32'(cs_v), 32'(6'b000010));
    check("wr_u1_reg", 32'(REG), 32'(3'b011));
    check("wr_u1_wdata", 32'(WDATA), 32'(8'hA5));
    check("wr_u1_nrw", 32'(nRW), 32'd1);
    check("wr_u1_nwait_hold", 32'(nWAIT), 32'd1);
    release_all(); repeat (4) tick();
    check("wr_u1_wr_pulses", 32'(n_wr - wr0), 32'd1);
    check("wr_u1_rd_pulses", 32'(n_rd - rd0), 32'd0);
    check("wr_u1_nwait_low", 32'(n_wlow - wl0), 32'd3);
    check("wr_u1_cs_released", 32'(cs_v), 32'd0);

    // read from CONS
    snap(); start(1'b1, 6'b101000, 8'h5A);
    repeat (8) tick();
    check("rd_cons_cs", 32'(cs_v), 32'(6'b100000));
    check("rd_cons_nrw", 32'(nRW), 32'd0);
    check("rd_cons_reg", 32'(REG), 32'(3'b000));
    check("rd_cons_wdata_kept", 32'(WDATA), 32'(8'hA5));
    check("rd_cons_rd_pulses", 32'(n_rd - rd0), 32'd1);
    check("rd_cons_rd_in_2nd_access", 32'(rd_at - cs_first), 32'd1);
    release_all();
    r = 0;
    do begin tick(); r++; end while ((cs_v != 6'b0 || nRW !== 1'b1) && r < 8);
    check("rd_cons_release_edges", 32'(r), 32'd3);
    repeat (2) tick();

    // unmapped read
    snap(); start(1'b1, 6'b111010, 8'h00);
    repeat (8) tick();
    check("unmapped_nwait_hold", 32'(nWAIT), 32'd1);
    release_all(); repeat (4) tick();
    check("unmapped_cs_seen", 32'(cs_seen), 32'd0);
    check("unmapped_strobes", 32'((n_rd - rd0) + (n_wr - wr0)), 32'd0);
    check("unmapped_nwait_low", 32'(n_wlow - wl0), 32'd3);

    // read from PIC aborted by nCS after one ACCESS cycle
    snap(); start(1'b1, 6'b100110, 8'h00);
    repeat (2) tick();
    nCS = 1'b1;
    repeat (6) tick();
    check("abort_cs", 32'(cs_v), 32'd0);
    check("abort_nwait", 32'(nWAIT), 32'd1);
    check("abort_nrw", 32'(nRW), 32'd1);
    check("abort_no_rd", 32'(n_rd - rd0), 32'd0);
    check("abort_cs_seen", 32'(cs_seen), 32'(6'b010000));
    check("abort_nwait_low", 32'(n_wlow - wl0), 32'd2);
    nRD = 1'b1; repeat (3) tick();

    // protocol error: both strobes low
    snap(); A = 6'b000000; nCS = 1'b0; nRD = 1'b0; nWE = 1'b0;
    repeat (6) tick();
    check("proto_nwait_low", 32'(n_wlow - wl0), 32'd0);
    check("proto_cs_seen", 32'(cs_seen), 32'd0);
    check("proto_strobes", 32'((n_rd - rd0) + (n_wr - wr0)), 32'd0);
    check("proto_nrw", 32'(nRW), 32'd1);
    release_all(); repeat (3) tick();

    // back-to-back writes to UART0 then UART3
    snap(); start(1'b0, 6'b000101, 8'h3C);
    repeat (8) tick();
    check("b2b_u0_cs", 32'(cs_v), 32'(6'b000001));
    check("b2b_u0_wdata", 32'(WDATA), 32'(8'h3C));
    check("b2b_u0_reg", 32'(REG), 32'(3'b101));
    release_all(); repeat (4) tick();
    check("b2b_u0_wr_pulses", 32'(n_wr - wr0), 32'd1);
    snap(); start(1'b0, 6'b011110, 8'hC3);
    repeat (8) tick();
    check("b2b_u3_cs", 32'(cs_v), 32'(6'b001000));
    check("b2b_u3_wdata", 32'(WDATA), 32'(8'hC3));
    check("b2b_u3_reg", 32'(REG), 32'(3'b110));
    release_all(); repeat (4) tick();
    check("b2b_u3_wr_pulses", 32'(n_wr - wr0), 32'd1);

    // asynchronous reset in the middle of an ACCESS to UART2
    snap(); start(1'b1, 6'b010001, 8'h00);
    repeat (4) tick();
    check("rst_pre_cs", 32'(cs_v), 32'(6'b000100));
    #1 nRESET = 1'b0;
    #1 check("rst_async", 32'(dut_v), 32'(RST_V));
    release_all();
    repeat (2) tick();
    nRESET = 1'b1;
    repeat (2) tick();
    snap(); start(1'b0, 6'b011001, 8'h77);
    repeat (8) tick();
    check("post_rst_cs", 32'(cs_v), 32'(6'b001000));
    release_all(); repeat (4) tick();
    check("post_rst_wr_pulses", 32'(n_wr - wr0), 32'd1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      A = 6'($urandom); DIN = 8'($urandom); nCS = 1'b0;
      if (kind == 0) begin nRD = 1'b0; nWE = 1'b0; end
      else if (kind < 5) nRD = 1'b0;
      else nWE = 1'b0;
      repeat ($urandom_range(1, 10)) tick();
      case ($urandom_range(0, 2))
        0:       nCS = 1'b1;
        1:       begin nRD = 1'b1; nWE = 1'b1; end
        default: release_all();
      endcase
      repeat ($urandom_range(0, 2)) tick();
      release_all();
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
